uart_rx_line_assembler: RTL and testbench

- Receive-side counterpart of the UART string-transmit path.
- Consumes the byte stream from uart_rx (rx_data/rx_data_valid) and assembles characters into a line buffer until CR or LF.
- Then presents the completed line as a byte stream with a valid/ready handshake, so downstream command logic can parse text typed at the terminal.
- Handles backspace editing, overflow, and bytes that arrive while a line is being drained.

---
 rtl/uart_rx_line_assembler.sv | 142 ++++++++++++++
 tb/tb_uart_rx_line_assembler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_line_assembler.sv
// Builds text lines from the uart_rx byte stream, with backspace editing.
// Each completed line is then streamed out one byte at a time over a valid/ready handshake.
module uart_rx_line_assembler #(
   parameter int MAX_LEN = 20,
   parameter int LEN_W   = 6
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic [7:0]       rx_data,
   input  logic             rx_data_valid,
   output logic             rx_data_ready,
   output logic             line_valid,
   output logic [LEN_W-1:0] line_len,
   output logic             line_overflow,
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic             rd_last,
   output logic [7:0]       drop_cnt
);

   typedef enum logic [1:0] {
      ST_FILL  = 2'b01,
      ST_DRAIN = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] count_q, count_d;
   logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             ovf_q, ovf_d;
   logic [7:0]       drop_q, drop_d;
   logic             wr_en;
   logic             is_term, is_bs;
   logic [7:0]       rd_byte;
   logic [7:0]       buf_q [MAX_LEN];

   // Explicit compare-per-entry mux keeps the pointer width independent of the array depth
   always_comb begin
      rd_byte = 8'h00;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (rd_ptr_q == LEN_W'(i)) rd_byte = buf_q[i];
      end
   end

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      len_d         = len_q;
      ovf_d         = ovf_q;
      drop_d        = drop_q;
      wr_en         = 1'b0;
      rx_data_ready = 1'b0;
      line_valid    = 1'b0;
      rd_valid      = 1'b0;
      rd_last       = 1'b0;
      rd_data       = 8'h00;
      is_term       = (rx_data == 8'h0D) || (rx_data == 8'h0A);
      is_bs         = (rx_data == 8'h08) || (rx_data == 8'h7F);

      case (state_q)
         ST_FILL: begin
            rx_data_ready = 1'b1;
            if (rx_data_valid) begin
               if (is_term) begin
                  // A terminator on an empty line is swallowed, so CRLF gives one line
                  if (count_q != '0) begin
                     len_d    = count_q;
                     rd_ptr_d = '0;
                     state_d  = ST_DRAIN;
                  end
               end else if (is_bs) begin
                  if (count_q != '0) count_d = count_q - LEN_W'(1);
               end else if (count_q < LEN_W'(MAX_LEN)) begin
                  wr_en   = 1'b1;
                  count_d = count_q + LEN_W'(1);
               end else begin
                  ovf_d = 1'b1;
               end
            end
         end

         ST_DRAIN: begin
            line_valid = 1'b1;
            rd_valid   = 1'b1;
            rd_data    = rd_byte;
            rd_last    = (rd_ptr_q == len_q - LEN_W'(1));
            if (rx_data_valid && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
            if (rd_ready) begin
               if (rd_last) begin
                  state_d  = ST_FILL;
                  count_d  = '0;
                  rd_ptr_d = '0;
                  len_d    = '0;
                  ovf_d    = 1'b0;
               end else begin
                  rd_ptr_d = rd_ptr_q + LEN_W'(1);
               end
            end
         end

         default: begin
            state_d  = ST_FILL;
            count_d  = '0;
            rd_ptr_d = '0;
            len_d    = '0;
            ovf_d    = 1'b0;
         end
      endcase
   end

   assign line_len      = len_q;
   assign line_overflow = ovf_q;
   assign drop_cnt      = drop_q;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q  <= ST_FILL;
         count_q  <= '0;
         rd_ptr_q <= '0;
         len_q    <= '0;
         ovf_q    <= 1'b0;
         drop_q   <= 8'h00;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         len_q    <= len_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
      end
   end

   // Buffer contents need no reset: nothing is read until count has re-filled them
   always_ff @(posedge sys_clk) begin
      for (int i = 0; i < MAX_LEN; i++) begin
         if (wr_en && (count_q == LEN_W'(i))) buf_q[i] <= rx_data;
      end
   end

endmodule

// File: tb/tb_uart_rx_line_assembler.sv
// Randomised and directed bench for uart_rx_line_assembler.
// Checks the DUT each cycle against a queue-based line model.
module tb_uart_rx_line_assembler;

   localparam int MAXL = 20;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_data_valid = 1'b0;
   logic       rx_data_ready;
   logic       line_valid;
   logic [5:0] line_len;
   logic       line_overflow;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_ready = 1'b0;
   logic       rd_last;
   logic [7:0] drop_cnt;

   uart_rx_line_assembler #(.MAX_LEN(MAXL), .LEN_W(6)) dut (
      .sys_clk       (sys_clk),
      .sys_rst       (sys_rst),
      .rx_data       (rx_data),
      .rx_data_valid (rx_data_valid),
      .rx_data_ready (rx_data_ready),
      .line_valid    (line_valid),
      .line_len      (line_len),
      .line_overflow (line_overflow),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .rd_last       (rd_last),
      .drop_cnt      (drop_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: text-level view of the line being typed and the line being read
   bit           m_drain   = 1'b0;
   byte unsigned m_cur[$];
   bit           m_cur_ovf = 1'b0;
   byte unsigned m_line[$];
   bit           m_line_ovf = 1'b0;
   int           m_idx     = 0;
   int           m_drops   = 0;
   bit           armed     = 1'b0;

   // Lines as actually received from the DUT
   string        g_cur = "";
   string        got_str[$];
   int           got_len[$];
   int           got_ovf[$];

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic check_str(input string name, input string act, input string exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
   endtask

   task automatic model_step(input bit rst, input bit v, input byte unsigned b, input bit rdy);
      if (rst) begin
         m_drain = 1'b0; m_cur.delete(); m_cur_ovf = 1'b0;
         m_idx = 0; m_drops = 0;
         return;
      end
      if (m_drain) begin
         if (v && m_drops < 255) m_drops++;
         if (rdy) begin
            if (m_idx == m_line.size() - 1) begin
               m_drain = 1'b0;
               m_cur.delete();
               m_cur_ovf = 1'b0;
            end else begin
               m_idx++;
            end
         end
      end else if (v) begin
         if (b == 8'h0D || b == 8'h0A) begin
            if (m_cur.size() > 0) begin
               m_line = m_cur;
               m_line_ovf = m_cur_ovf;
               m_idx = 0;
               m_drain = 1'b1;
            end
         end else if (b == 8'h08 || b == 8'h7F) begin
            if (m_cur.size() > 0) void'(m_cur.pop_back());
         end else if (m_cur.size() < MAXL) begin
            m_cur.push_back(b);
         end else begin
            m_cur_ovf = 1'b1;
         end
      end
   endtask

   task automatic compare();
      if (!armed) return;
      check("rd_valid", int'(rd_valid), int'(m_drain));
      check("line_valid", int'(line_valid), int'(m_drain));
      check("rx_data_ready", int'(rx_data_ready), int'(!m_drain));
      check("drop_cnt", int'(drop_cnt), m_drops);
      if (m_drain) begin
         check("rd_data", int'(rd_data), int'(m_line[m_idx]));
         check("rd_last", int'(rd_last), int'(m_idx == m_line.size() - 1));
         check("line_len", int'(line_len), m_line.size());
         check("line_overflow", int'(line_overflow), int'(m_line_ovf));
      end else begin
         check("rd_last_idle", int'(rd_last), 0);
      end
   endtask

   // One clock: check outputs at the falling edge, then drive the next inputs
   task automatic cycle(input bit rst, input bit v, input byte unsigned b, input bit rdy);
      bit         o_valid, o_last, o_ovf;
      logic [7:0] o_data;
      int         o_len;
      @(negedge sys_clk);
      compare();
      o_valid = rd_valid; o_last = rd_last; o_data = rd_data;
      o_len = int'(line_len); o_ovf = line_overflow;
      sys_rst = rst; rx_data_valid = v; rx_data = b; rd_ready = rdy;
      if (rst) begin
         g_cur = "";
      end else if (o_valid && rdy) begin
         g_cur = $sformatf("%s%c", g_cur, o_data);
         if (o_last) begin
            got_str.push_back(g_cur);
            got_len.push_back(o_len);
            got_ovf.push_back(int'(o_ovf));
            g_cur = "";
         end
      end
      model_step(rst, v, b, rdy);
      if (rst) armed = 1'b1;
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, rdy);
   endtask

   task automatic send_str(input string s, input bit rdy, input int gap);
      for (int i = 0; i < s.len(); i++) begin
         cycle(1'b0, 1'b1, s[i], rdy);
         idle(gap, rdy);
      end
   endtask

   task automatic drain(output int n);
      n = 0;
      while (m_drain && n < 200) begin
         cycle(1'b0, 1'b0, 8'h00, 1'b1);
         n++;
      end
      if (m_drain) check("drain_timeout", n, -1);
   endtask

   task automatic check_last_line(input string tag, input string s, input int len, input int ovf);
      if (got_str.size() == 0) begin
         check({tag, "_present"}, 0, 1);
      end else begin
         check_str({tag, "_text"}, got_str[$], s);
         check({tag, "_len"}, got_len[$], len);
         check({tag, "_ovf"}, got_ovf[$], ovf);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_rx_ready"}, int'(rx_data_ready), 1);
      check({tag, "_line_valid"}, int'(line_valid), 0);
      check({tag, "_rd_valid"}, int'(rd_valid), 0);
      check({tag, "_rd_last"}, int'(rd_last), 0);
      check({tag, "_rd_data"}, int'(rd_data), 0);
      check({tag, "_line_len"}, int'(line_len), 0);
      check({tag, "_ovf"}, int'(line_overflow), 0);
      check({tag, "_drop"}, int'(drop_cnt), 0);
   endtask

   initial begin
      int    n;
      int    cnt_before;
      string s;
      byte unsigned b;
      bit    v, rdy, rst;

      cycle(1'b1, 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 1'b0, 8'h00, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
      check_reset_values("reset");

      // CRLF gives exactly one line
      send_str("AB\r", 1'b1, 3);
      drain(n);
      check_last_line("crlf", "AB", 2, 0);
      cnt_before = got_str.size();
      send_str("\n", 1'b1, 3);
      check("crlf_no_second_line", got_str.size(), cnt_before);
      check("crlf_rx_ready", int'(rx_data_ready), 1);

      // Backspace editing
      send_str($sformatf("AX%cB\r", 8'h08), 1'b1, 1);
      drain(n);
      check_last_line("bksp", "AB", 2, 0);
      send_str($sformatf("%cC\r", 8'h08), 1'b1, 1);
      drain(n);
      check_last_line("bksp_first", "C", 1, 0);

      // Overflow
      s = "";
      for (int i = 0; i < 25; i++) s = $sformatf("%s%c", s, 8'(97 + i));
      send_str({s, "\r"}, 1'b0, 0);
      drain(n);
      check_last_line("ovf", "abcdefghijklmnopqrst", 20, 1);
      send_str("Z\r", 1'b0, 0);
      drain(n);
      check_last_line("ovf_clear", "Z", 1, 0);

      // Stall then stream at one byte per cycle
      send_str("ABC\r", 1'b0, 0);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b0, 8'h00, 1'b0);
         check("stall_data", int'(rd_data), 8'h41);
      end
      drain(n);
      check("stream_cycles", n, 3);
      check_last_line("stall", "ABC", 3, 0);

      // Bytes during drain are dropped and counted
      send_str("HELLO\r", 1'b0, 0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h61, 1'b0);
      idle(1, 1'b0);
      check("drop3", int'(drop_cnt), 3);
      drain(n);
      check_last_line("hello", "HELLO", 5, 0);
      send_str("Q\r", 1'b0, 0);
      drain(n);
      check_last_line("after_drop", "Q", 1, 0);
      send_str("X\r", 1'b0, 0);
      for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 8'h62, 1'b0);
      idle(1, 1'b0);
      check("drop_sat", int'(drop_cnt), 255);
      drain(n);

      // Reset in the middle of a drain
      send_str("HELLO\r", 1'b0, 0);
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
      check("mid_drain_data", int'(rd_data), 8'h4C);
      cnt_before = got_str.size();
      cycle(1'b1, 1'b0, 8'h00, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
      check_reset_values("midrst");
      send_str("OK\r", 1'b1, 0);
      drain(n);
      check("midrst_lines", got_str.size(), cnt_before + 1);
      check_last_line("midrst_ok", "OK", 2, 0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         v   = ($urandom_range(0, 2) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 499) == 0);
         case ($urandom_range(0, 24))
            0:       b = 8'h0D;
            1:       b = 8'h0A;
            2:       b = 8'h08;
            3:       b = 8'h7F;
            default: b = 8'(8'h20 + $urandom_range(0, 94));
         endcase
         cycle(rst, v, b, rdy);
      end
      drain(n);
      idle(2, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
